// File: rtl/am_deskew_calc_pkg.sv
// Shared definitions for the alignment-marker deskew calculator: default
// sizing and the one-hot measurement state encoding.
package am_deskew_calc_pkg;

  localparam int N_LANES_DEF  = 20;
  localparam int MAX_SKEW_DEF = 16;

  // One-hot, matching the encoding style of the upstream lock FSM.
  typedef enum logic [4:0] {
    ST_IDLE       = 5'b00001,
    ST_WAIT_FIRST = 5'b00010,
    ST_COUNTING   = 5'b00100,
    ST_CALC       = 5'b01000,
    ST_LOCKED     = 5'b10000
  } deskew_state_e;

endpackage

// File: rtl/am_deskew_calc_if.sv
// Bundle of lock-FSM inputs and deskew-FIFO outputs of the deskew calculator.
// The master side drives the per-lane lock/SOL/resync strobes, the slave side
// is the calculator itself.
interface am_deskew_calc_if
  import am_deskew_calc_pkg::*;
#(
  parameter int N_LANES = N_LANES_DEF,
  parameter int NB_SKEW = $clog2(MAX_SKEW_DEF + 1)
);

  logic                       i_enable;
  logic                       i_valid;
  logic [N_LANES-1:0]         i_am_lock;
  logic [N_LANES-1:0]         i_start_of_lane;
  logic [N_LANES-1:0]         i_resync;
  logic [N_LANES*NB_SKEW-1:0] o_lane_delay;
  logic                       o_delay_valid;
  logic                       o_load_delay;
  logic                       o_deskew_error;

  modport master (
    output i_enable, i_valid, i_am_lock, i_start_of_lane, i_resync,
    input  o_lane_delay, o_delay_valid, o_load_delay, o_deskew_error
  );

  modport slave (
    input  i_enable, i_valid, i_am_lock, i_start_of_lane, i_resync,
    output o_lane_delay, o_delay_valid, o_load_delay, o_deskew_error
  );

endinterface

// File: rtl/am_deskew_calc_max_tree.sv
// Combinational maximum over N_VALUES unsigned values packed NB bits apart.
// Finds the latest-arriving lane so every other lane can be delayed to it.
module am_deskew_calc_max_tree
  import am_deskew_calc_pkg::*;
#(
  parameter int N_VALUES = N_LANES_DEF,
  parameter int NB       = $clog2(MAX_SKEW_DEF + 1)
) (
  input  logic [N_VALUES*NB-1:0] values_s,
  output logic [NB-1:0]          max_value_s
);

  // Running maximum across all packed values.
  always_comb begin
    max_value_s = values_s[NB-1:0];
    for (int i = 1; i < N_VALUES; i++) begin
      if (values_s[i*NB +: NB] > max_value_s) begin
        max_value_s = values_s[i*NB +: NB];
      end else begin
        max_value_s = max_value_s;
      end
    end
  end

endmodule

// File: rtl/am_deskew_calc.sv
// Alignment-marker deskew calculator. Timestamps each lane's start-of-lane
// pulse relative to the first lane seen, then loads per-lane delays equal to
// (latest arrival - own arrival) so the deskew FIFOs line all lanes up.
// Any resync request or lock loss throws the measurement away.
module am_deskew_calc
  import am_deskew_calc_pkg::*;
#(
  parameter int N_LANES  = N_LANES_DEF,
  parameter int MAX_SKEW = MAX_SKEW_DEF,
  parameter int NB_SKEW  = $clog2(MAX_SKEW + 1)
) (
  input logic             i_clock,
  input logic             i_reset_n,
  am_deskew_calc_if.slave bus
);

  localparam logic [NB_SKEW-1:0] SKEW_LIMIT = NB_SKEW'(MAX_SKEW);
  localparam logic [NB_SKEW-1:0] CNT_ZERO   = {NB_SKEW{1'b0}};
  localparam logic [NB_SKEW-1:0] CNT_ONE    = NB_SKEW'(1);

  deskew_state_e              state_r;
  logic [NB_SKEW-1:0]         counter_r;
  logic [N_LANES-1:0]         arrived_r;
  logic [N_LANES*NB_SKEW-1:0] arrival_r;
  logic [N_LANES*NB_SKEW-1:0] delay_r;
  logic                       delay_valid_r;
  logic                       load_delay_r;
  logic                       error_r;

  logic                       step_s;
  logic                       all_lock_s;
  logic                       any_resync_s;
  logic [N_LANES-1:0]         arrived_next_s;
  logic                       dup_sol_s;
  logic                       mask_full_s;
  logic                       timeout_s;
  logic [NB_SKEW-1:0]         max_arr_s;
  logic [N_LANES*NB_SKEW-1:0] delay_calc_s;

  // Per-step qualifiers shared by every state.
  always_comb begin
    step_s         = bus.i_enable & bus.i_valid;
    all_lock_s     = &bus.i_am_lock;
    any_resync_s   = |bus.i_resync;
    arrived_next_s = arrived_r | bus.i_start_of_lane;
    dup_sol_s      = |(arrived_r & bus.i_start_of_lane);
    mask_full_s    = &arrived_next_s;
    // The counter equals the age of the current step; the last lane may still
    // arrive at age MAX_SKEW, after that the spread is out of range.
    timeout_s      = (counter_r >= SKEW_LIMIT);
  end

  am_deskew_calc_max_tree #(
    .N_VALUES (N_LANES),
    .NB       (NB_SKEW)
  ) u_max_tree (
    .values_s    (arrival_r),
    .max_value_s (max_arr_s)
  );

  // Delay of each lane relative to the latest arrival; never negative.
  always_comb begin
    delay_calc_s = {(N_LANES*NB_SKEW){1'b0}};
    for (int i = 0; i < N_LANES; i++) begin
      delay_calc_s[i*NB_SKEW +: NB_SKEW] = max_arr_s - arrival_r[i*NB_SKEW +: NB_SKEW];
    end
  end

  // Measurement FSM with all registered outputs; only steps advance it.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r       <= ST_IDLE;
      counter_r     <= CNT_ZERO;
      arrived_r     <= {N_LANES{1'b0}};
      arrival_r     <= {(N_LANES*NB_SKEW){1'b0}};
      delay_r       <= {(N_LANES*NB_SKEW){1'b0}};
      delay_valid_r <= 1'b0;
      load_delay_r  <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      load_delay_r <= 1'b0;
      if (step_s) begin
        case (state_r)
          ST_IDLE: begin
            if (all_lock_s) begin
              state_r <= ST_WAIT_FIRST;
            end
          end
          default: begin
            if (!all_lock_s) begin
              // Lock loss: delays stay as they were but are no longer usable.
              state_r       <= ST_IDLE;
              delay_valid_r <= 1'b0;
            end else if (any_resync_s) begin
              state_r       <= ST_WAIT_FIRST;
              delay_valid_r <= 1'b0;
              error_r       <= 1'b0;
              arrived_r     <= {N_LANES{1'b0}};
              counter_r     <= CNT_ZERO;
            end else begin
              case (state_r)
                ST_WAIT_FIRST: begin
                  error_r   <= 1'b0;
                  arrived_r <= bus.i_start_of_lane;
                  counter_r <= CNT_ZERO;
                  if (|bus.i_start_of_lane) begin
                    for (int i = 0; i < N_LANES; i++) begin
                      if (bus.i_start_of_lane[i]) begin
                        arrival_r[i*NB_SKEW +: NB_SKEW] <= CNT_ZERO;
                      end
                    end
                    counter_r <= CNT_ONE;
                    state_r   <= (&bus.i_start_of_lane) ? ST_CALC : ST_COUNTING;
                  end
                end
                ST_COUNTING: begin
                  for (int i = 0; i < N_LANES; i++) begin
                    if (bus.i_start_of_lane[i] && !arrived_r[i]) begin
                      arrival_r[i*NB_SKEW +: NB_SKEW] <= counter_r;
                    end
                  end
                  arrived_r <= arrived_next_s;
                  counter_r <= counter_r + CNT_ONE;
                  if (dup_sol_s) begin
                    error_r <= 1'b1;
                    state_r <= ST_WAIT_FIRST;
                  end else if (mask_full_s) begin
                    state_r <= ST_CALC;
                  end else if (timeout_s) begin
                    error_r <= 1'b1;
                    state_r <= ST_WAIT_FIRST;
                  end
                end
                ST_CALC: begin
                  delay_r       <= delay_calc_s;
                  load_delay_r  <= 1'b1;
                  delay_valid_r <= 1'b1;
                  state_r       <= ST_LOCKED;
                end
                ST_LOCKED: begin
                  state_r <= ST_LOCKED;
                end
                default: begin
                  // Corrupted one-hot code: fall back to a clean start.
                  state_r       <= ST_IDLE;
                  delay_valid_r <= 1'b0;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  assign bus.o_lane_delay   = delay_r;
  assign bus.o_delay_valid  = delay_valid_r;
  assign bus.o_load_delay   = load_delay_r;
  assign bus.o_deskew_error = error_r;

endmodule

// File: tb/tb_am_deskew_calc.sv
// Bench for am_deskew_calc: directed scenarios followed by random traffic,
// all compared against an arrival-timestamp model of the deskew measurement.
module tb_am_deskew_calc;

  localparam int NL = 4;
  localparam int MS = 4;
  localparam int NB = $clog2(MS + 1);
  localparam logic [NL-1:0] ALL = 4'b1111;
  localparam logic [NL-1:0] NON = 4'b0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  am_deskew_calc_if #(.N_LANES(NL), .NB_SKEW(NB)) bus ();

  am_deskew_calc #(.N_LANES(NL), .MAX_SKEW(MS), .NB_SKEW(NB)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // Model: measurement phase plus step-number timestamps per lane.
  localparam int P_OFF = 0, P_ARMED = 1, P_MEAS = 2, P_PEND = 3, P_DONE = 4;
  int          phase;
  int          step_no;
  int          first_step;
  int          arr [NL];
  logic [NL-1:0] got_v;
  int          exp_delay [NL];
  logic        exp_valid, exp_load, exp_err;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = P_OFF; step_no = 0; first_step = 0; got_v = '0;
    exp_valid = 1'b0; exp_load = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < NL; i++) begin
      arr[i] = 0; exp_delay[i] = 0;
    end
  endtask

  task automatic model_step();
    int age, mx;
    logic [NL-1:0] sol;
    sol = bus.i_start_of_lane;
    exp_load = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!(bus.i_enable && bus.i_valid)) return;
    step_no++;
    if (phase == P_OFF) begin
      if (&bus.i_am_lock) phase = P_ARMED;
      return;
    end
    if (!(&bus.i_am_lock)) begin
      phase = P_OFF; exp_valid = 1'b0;
      return;
    end
    if (|bus.i_resync) begin
      phase = P_ARMED; exp_valid = 1'b0; exp_err = 1'b0; got_v = '0;
      return;
    end
    case (phase)
      P_ARMED: begin
        exp_err = 1'b0;
        got_v = sol;
        if (|sol) begin
          first_step = step_no;
          for (int i = 0; i < NL; i++) if (sol[i]) arr[i] = 0;
          phase = (&sol) ? P_PEND : P_MEAS;
        end
      end
      P_MEAS: begin
        age = step_no - first_step;
        if (|(sol & got_v)) begin
          exp_err = 1'b1; phase = P_ARMED;
        end else begin
          for (int i = 0; i < NL; i++) if (sol[i]) arr[i] = age;
          got_v = got_v | sol;
          if (&got_v) phase = P_PEND;
          else if (age >= MS) begin
            exp_err = 1'b1; phase = P_ARMED;
          end
        end
      end
      P_PEND: begin
        mx = 0;
        for (int i = 0; i < NL; i++) if (arr[i] > mx) mx = arr[i];
        for (int i = 0; i < NL; i++) exp_delay[i] = mx - arr[i];
        exp_load = 1'b1; exp_valid = 1'b1; phase = P_DONE;
      end
      default: ;
    endcase
  endtask

  function automatic logic [NL*NB-1:0] exp_flat();
    logic [NL*NB-1:0] f;
    f = '0;
    for (int i = 0; i < NL; i++) f[i*NB +: NB] = NB'(exp_delay[i]);
    return f;
  endfunction

  function automatic int dut_lane(input int i);
    return int'(bus.o_lane_delay[i*NB +: NB]);
  endfunction

  task automatic compare_all();
    check("lane_delay",   32'(bus.o_lane_delay),   32'(exp_flat()));
    check("delay_valid",  32'(bus.o_delay_valid),  32'(exp_valid));
    check("load_delay",   32'(bus.o_load_delay),   32'(exp_load));
    check("deskew_error", 32'(bus.o_deskew_error), 32'(exp_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic [NL-1:0] lock, input logic [NL-1:0] sol, input logic [NL-1:0] rsy);
    bus.i_enable = 1'b1; bus.i_valid = 1'b1;
    bus.i_am_lock = lock; bus.i_start_of_lane = sol; bus.i_resync = rsy;
    tick();
  endtask

  task automatic pin_delays(input string nm, input int e0, input int e1, input int e2, input int e3);
    int e [NL];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < NL; i++) begin
      check($sformatf("%s_dut_d%0d", nm, i), 32'(dut_lane(i)), 32'(e[i]));
      check($sformatf("%s_model_d%0d", nm, i), 32'(exp_delay[i]), 32'(e[i]));
    end
  endtask

  initial begin
    bus.i_enable = 1'b0; bus.i_valid = 1'b0;
    bus.i_am_lock = NON; bus.i_start_of_lane = NON; bus.i_resync = NON;
    model_reset();
    @(negedge clk);
    compare_all();
    check("reset_valid", 32'(bus.o_delay_valid), 32'd0);
    check("reset_err",   32'(bus.o_deskew_error), 32'd0);
    pin_delays("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Skewed arrivals 0,0,3,1.
    drive(ALL, NON, NON);
    drive(ALL, 4'b0011, NON);
    drive(ALL, 4'b1000, NON);
    drive(ALL, NON, NON);
    drive(ALL, 4'b0100, NON);
    check("t1_load_early", 32'(bus.o_load_delay), 32'd0);
    drive(ALL, NON, NON);
    check("t1_load",  32'(bus.o_load_delay),  32'd1);
    check("t1_valid", 32'(bus.o_delay_valid), 32'd1);
    pin_delays("t1", 3, 3, 0, 2);
    drive(ALL, NON, NON);
    check("t1_load_end", 32'(bus.o_load_delay), 32'd0);

    // Non-step cycle: a resync must not be seen.
    bus.i_enable = 1'b0; bus.i_resync = 4'b0010;
    tick();
    check("hold_valid", 32'(bus.o_delay_valid), 32'd1);

    // Resync from LOCKED, then arrivals 0,1,0,0.
    drive(ALL, NON, 4'b0010);
    check("t4_valid_drop", 32'(bus.o_delay_valid), 32'd0);
    drive(ALL, 4'b1101, NON);
    drive(ALL, 4'b0010, NON);
    drive(ALL, NON, NON);
    pin_delays("t4", 1, 0, 1, 1);

    // All lanes together.
    drive(ALL, NON, 4'b0001);
    drive(ALL, 4'b1111, NON);
    check("t2_valid_1step", 32'(bus.o_delay_valid), 32'd0);
    drive(ALL, NON, NON);
    check("t2_valid_2step", 32'(bus.o_delay_valid), 32'd1);
    check("t2_load", 32'(bus.o_load_delay), 32'd1);
    pin_delays("t2", 0, 0, 0, 0);

    // Lane 3 never arrives: timeout.
    drive(ALL, NON, 4'b0001);
    drive(ALL, 4'b0111, NON);
    for (int k = 0; k < 3; k++) drive(ALL, NON, NON);
    check("t3_err_early", 32'(bus.o_deskew_error), 32'd0);
    drive(ALL, NON, NON);
    check("t3_err", 32'(bus.o_deskew_error), 32'd1);
    check("t3_valid", 32'(bus.o_delay_valid), 32'd0);
    drive(ALL, NON, NON);
    check("t3_err_clear", 32'(bus.o_deskew_error), 32'd0);

    // Lock loss mid-measurement, then arrivals 0,2,1,0.
    drive(ALL, 4'b1001, NON);
    drive(4'b1011, NON, NON);
    check("t5_err", 32'(bus.o_deskew_error), 32'd0);
    check("t5_valid", 32'(bus.o_delay_valid), 32'd0);
    drive(ALL, NON, NON);
    drive(ALL, 4'b1001, NON);
    drive(ALL, 4'b0100, NON);
    drive(ALL, 4'b0010, NON);
    drive(ALL, NON, NON);
    pin_delays("t5", 2, 0, 1, 2);

    // Duplicate SOL on lane 0, then a clean restart.
    drive(ALL, NON, 4'b0100);
    drive(ALL, 4'b0001, NON);
    drive(ALL, 4'b0010, NON);
    drive(ALL, 4'b0001, NON);
    check("t6_err", 32'(bus.o_deskew_error), 32'd1);
    drive(ALL, 4'b0011, NON);
    check("t6_err_clear", 32'(bus.o_deskew_error), 32'd0);
    drive(ALL, 4'b1100, NON);
    drive(ALL, NON, NON);
    pin_delays("t6", 1, 1, 0, 0);

    // Reset in the middle of a measurement.
    drive(ALL, NON, 4'b0001);
    drive(ALL, 4'b0001, NON);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_valid", 32'(bus.o_delay_valid), 32'd0);
    pin_delays("rst", 0, 0, 0, 0);
    drive(ALL, NON, NON);
    rst_n = 1'b1;

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      bus.i_enable = ($urandom_range(0, 9) != 0);
      bus.i_valid  = ($urandom_range(0, 9) != 0);
      bus.i_am_lock = ($urandom_range(0, 59) == 0) ? NL'($urandom) : ALL;
      for (int i = 0; i < NL; i++) begin
        if (got_v[i]) bus.i_start_of_lane[i] = ($urandom_range(0, 29) == 0);
        else          bus.i_start_of_lane[i] = ($urandom_range(0, 2) == 0);
      end
      bus.i_resync = ($urandom_range(0, 79) == 0) ? (NL'(1) << $urandom_range(0, NL - 1)) : NON;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/am_deskew_calc.md
Name: am_deskew_calc

Overview:
- Sits directly downstream of the per-lane alignment-marker lock FSMs.
- Collects each lane's start_of_lane pulse and resync request, and measures the relative arrival skew of the AMs across all lanes in 66b-block cycles.
- Outputs a per-lane delay that the deskew FIFOs apply so that all lanes are output aligned.
- Recalculates whenever any lane requests resync or loses AM lock.

Parameters:
- N_LANES, 20, number of PCS lanes (one lock FSM each).
- MAX_SKEW, 16, largest tolerated arrival spread in valid cycles; must be >= 1.
- NB_SKEW, $clog2(MAX_SKEW+1), width of one lane delay and of the arrival counter.

Ports:
- i_clock  in  1  block clock.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  global enable; when low, all state holds.
- i_valid  in  1  block-valid strobe; state advances only when i_enable && i_valid.
- i_am_lock  in  N_LANES  per-lane AM lock from the lock FSMs.
- i_start_of_lane  in  N_LANES  per-lane SOL pulse, one valid cycle wide.
- i_resync  in  N_LANES  per-lane resync_by_am_start pulse.
- o_lane_delay  out  N_LANES*NB_SKEW  delay of lane i in bits [i*NB_SKEW +: NB_SKEW].
- o_delay_valid  out  1  delays are stable and usable.
- o_load_delay  out  1  one-cycle pulse when o_lane_delay takes new values.
- o_deskew_error  out  1  sticky error; cleared on entry to WAIT_FIRST.

Behaviour:
- Reset values (async, on i_reset_n=0): state=IDLE, all delays 0, o_delay_valid=0, o_load_delay=0, o_deskew_error=0, arrival counter 0, arrived mask 0.
- "Step" below means a cycle with i_enable && i_valid. Nothing changes on non-step cycles; o_load_delay is deasserted on any cycle it is not explicitly set.
- all_lock = &i_am_lock. any_resync = |i_resync.
- IDLE: go to WAIT_FIRST when all_lock.
- WAIT_FIRST:
  - Clear o_deskew_error, the arrived mask and the counter.
  - On a step with |i_start_of_lane: every lane asserting SOL captures arrival 0; arrived |= SOL; counter=1; go to COUNTING.
  - If all lanes arrive together, go directly to CALC.
- COUNTING, on each step:
  - Lanes with SOL && !arrived capture arrival=counter and set their arrived bit; counter then increments.
  - SOL from a lane already arrived: set o_deskew_error, go to WAIT_FIRST.
  - Counter reaching MAX_SKEW+1 with the mask still incomplete: set o_deskew_error, go to WAIT_FIRST. The error is set in the same cycle as the transition and is visible for exactly that one cycle, because WAIT_FIRST clears it.
  - When the mask becomes all-ones (including through this cycle's arrivals): go to CALC.
- CALC (one step):
  - max_arr = maximum captured arrival.
  - delay_i = max_arr - arrival_i (unsigned, NB_SKEW bits, never negative).
  - Register all delays, pulse o_load_delay, go to LOCKED.
- LOCKED:
  - o_delay_valid=1 and delays are held.
  - SOL pulses are ignored.
- Abort rules, in priority order, evaluated every step in any state except IDLE:
  - !all_lock → IDLE, o_delay_valid=0, delays held.
  - any_resync → WAIT_FIRST, o_delay_valid=0.
- Latency: o_load_delay and o_delay_valid assert 2 steps after the step carrying the last lane's SOL (one step for the CALC transition, one for the register).
- A resync arriving on the same step as the last SOL takes precedence over completion and restarts the measurement.
- Asserting reset mid-measurement returns to IDLE immediately, with no partial outputs.

Decomposition:
- Shared package:
  - State encoding: IDLE, WAIT_FIRST, COUNTING, CALC, LOCKED (one-hot, as in the lock FSM).
  - N_LANES and MAX_SKEW defaults.
- Sub-module max_tree: parameterised combinational maximum over N_LANES values of NB_SKEW bits. Used in CALC; may be registered once if timing requires, which adds one step of latency and shifts the test plan's expected cycles by one.

Test Plan:
- N_LANES=4, all locked; SOLs at steps t, t, t+3, t+1 (lanes 0..3) → arrivals 0,0,3,1; delays 3,3,0,2; o_load_delay at t+5.
- All four SOL on the same step → direct to CALC; delays all 0; o_delay_valid 2 steps later.
- MAX_SKEW=4; lanes 0-2 at t, lane 3 never → o_deskew_error high at step t+4; return to WAIT_FIRST; o_delay_valid stays 0.
- From LOCKED with delays 3,3,0,2, pulse i_resync[1] → o_delay_valid drops next step. New SOLs at t, t+1, t, t → delays 1,0,1,1.
- Drop i_am_lock[2] during COUNTING → IDLE; error stays 0. Re-lock, then skew 0,2,1,0 → delays 2,0,1,2.
- Lane 0 SOL twice before lane 3 arrives → o_deskew_error pulses; measurement restarts. Also assert i_reset_n low mid-COUNTING → all outputs 0 asynchronously.
